// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//   Run controller and observer for the monocycle CPU. A run has three phases:
//   the CPU is held in reset for RST_CYCLES cycles, it then executes until the
//   PC reaches a halt address or a cycle budget runs out, and finally the first
//   NUM_REGS register-file entries are streamed out over a valid/ready port.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : begins a run (accepted only when idle or done)
//   max_cycles        : run budget latched on start, 0 = unlimited
//   halt_pc           : halt address latched on start
//   cpu_pc            : CPU program counter being observed
//   cpu_reset, cpu_en : reset and clock-enable driven into the CPU
//   rf_raddr/rf_rdata : monitor read port into the register file (comb read)
//   dump_valid/ready  : snapshot stream handshake
//   dump_idx/data     : register index and value of the current snapshot word
//   cycles            : executed cycles of the last/current run (saturating)
//   busy, done        : run in progress / run finished
//   timeout           : last run ended on budget rather than on halt_pc
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 10,
  parameter int RF_AW      = 4,
  parameter int NUM_REGS   = 4,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [PC_W-1:0]   halt_pc,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic [RF_AW-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [RF_AW-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [CNT_W-1:0]  cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RESET, ST_RUN, ST_DUMP, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [PC_W-1:0]     halt_q, halt_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                timeout_q, timeout_d;
  logic [RF_AW-1:0]    idx_q, idx_d;
  logic                dump_valid_q, dump_valid_d;
  logic [RF_AW-1:0]    dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;

  logic                start_ok;
  logic                rst_last;
  logic                halt_hit;
  logic                budget_hit;
  logic                xfer;
  logic                last_idx;
  logic [CNT_W:0]      cycles_inc;

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rst_last   = (rst_cnt_q == RST_W'(RST_CYCLES - 1));
  assign halt_hit   = (cpu_pc == halt_q);
  // Extra bit so the budget compare cannot wrap when cycles is saturated.
  assign cycles_inc = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};
  assign budget_hit = (max_q != '0) && (cycles_inc == {1'b0, max_q});
  assign xfer       = dump_valid_q && dump_ready;
  assign last_idx   = (idx_q == RF_AW'(NUM_REGS - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      max_q        <= '0;
      halt_q       <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      max_q        <= max_d;
      halt_q       <= halt_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      idx_q        <= idx_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  if (start_ok) state_d = ST_RESET;
      ST_RESET: if (rst_last) state_d = ST_RUN;
      ST_RUN:   if (halt_hit || budget_hit) state_d = ST_DUMP;
      ST_DUMP:  if (xfer && last_idx) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    max_d        = max_q;
    halt_d       = halt_q;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    idx_d        = idx_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;

    case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start_ok) begin
          max_d        = max_cycles;
          halt_d       = halt_pc;
          cycles_d     = '0;
          timeout_d    = 1'b0;
          rst_cnt_d    = '0;
          idx_d        = '0;
          dump_valid_d = 1'b0;
        end
      end
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      ST_RUN: begin
        // The halting cycle itself is counted; halt takes priority over budget.
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
        if (halt_hit) begin
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          timeout_d = 1'b1;
        end
      end
      ST_DUMP: begin
        // A word is captured whenever nothing is pending, so there is always a
        // one-cycle gap after each transfer while the next address is read.
        if (!dump_valid_q) begin
          dump_valid_d = 1'b1;
          dump_idx_d   = idx_q;
          dump_data_d  = rf_rdata;
        end else if (xfer) begin
          dump_valid_d = 1'b0;
          if (!last_idx) begin
            idx_d = idx_q + RF_AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cpu_reset = 1'b0;
    cpu_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rf_raddr  = '0;
    case (state_q)
      ST_IDLE:  cpu_reset = 1'b1;
      ST_RESET: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
      end
      ST_RUN: begin
        cpu_en = 1'b1;
        busy   = 1'b1;
      end
      ST_DUMP: begin
        busy     = 1'b1;
        rf_raddr = idx_q;
      end
      ST_DONE:  done = 1'b1;
      default:  cpu_reset = 1'b1;
    endcase
  end

  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign cycles     = cycles_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Testbench for cpu_run_monitor: a small behavioural CPU (PC counter writing a
// salted value into rf[pc mod 16] each enabled cycle) drives the monitor. The
// stimulus computes each run's outcome from the halt/budget rules and pushes
// the expected snapshot and run summary into queues; a monitor process pops
// and compares whenever the DUT transfers a word or raises done.
module tb_cpu_run_monitor;
  localparam int DATA_W     = 16;
  localparam int PC_W       = 10;
  localparam int RF_AW      = 4;
  localparam int NUM_REGS   = 4;
  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  max_cycles;
  logic [PC_W-1:0]   halt_pc;
  logic [PC_W-1:0]   cpu_pc;
  logic              cpu_reset;
  logic              cpu_en;
  logic [RF_AW-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [RF_AW-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic [CNT_W-1:0]  cycles;
  logic              busy;
  logic              done;
  logic              timeout;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RF_AW(RF_AW), .NUM_REGS(NUM_REGS),
    .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
    .halt_pc(halt_pc), .cpu_pc(cpu_pc), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .cycles(cycles), .busy(busy), .done(done), .timeout(timeout)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { int idx; logic [DATA_W-1:0] data; } word_t;
  typedef struct { int cyc; int to; } run_t;
  word_t dump_q[$];
  run_t  run_q[$];

  logic [DATA_W-1:0] salt = '0;
  logic [DATA_W-1:0] rf  [16];
  logic [DATA_W-1:0] mrf [16];
  int ready_mode = 0;

  function automatic logic [DATA_W-1:0] wfun(input int p);
    return DATA_W'(p * 37) + salt;
  endfunction

  function automatic logic [DATA_W-1:0] init_val(input int i);
    case (i)
      0: return 16'd0;
      1: return 16'd5;
      2: return 16'd7;
      3: return 16'd12;
      default: return DATA_W'(16 + i);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural CPU and register file
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
      cpu_pc <= '0;
    end else if (cpu_reset) begin
      cpu_pc <= '0;
    end else if (cpu_en) begin
      rf[cpu_pc[3:0]] <= wfun(int'(cpu_pc));
      cpu_pc <= cpu_pc + 1'b1;
    end
  end

  // Consumer ready generator: 0 always ready, 1 random, 2 stall idx 1 for
  // three cycles then toggle, other values never ready.
  int hold_cnt  = 0;
  int last_mode = 0;
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode != last_mode) hold_cnt = 0;
      last_mode = ready_mode;
      case (ready_mode)
        0: dump_ready = 1'b1;
        1: dump_ready = 1'($urandom_range(0, 1));
        2: begin
          if (dump_valid && dump_idx == 4'd1 && hold_cnt < 3) begin
            dump_ready = 1'b0;
            hold_cnt++;
          end else begin
            dump_ready = ~dump_ready;
          end
        end
        default: dump_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  bit                m_stall = 1'b0;
  logic [RF_AW-1:0]  m_sidx;
  logic [DATA_W-1:0] m_sdata;
  bit                m_prev_done = 1'b0;
  int                m_en_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_stall     = 1'b0;
        m_prev_done = 1'b0;
        m_en_cnt    = 0;
      end else begin
        if (cpu_reset) m_en_cnt = 0;
        else if (cpu_en) m_en_cnt++;
        if (m_stall) begin
          chk("stall_valid", 32'(dump_valid), 32'd1);
          chk("stall_idx", 32'(dump_idx), 32'(m_sidx));
          chk("stall_data", 32'(dump_data), 32'(m_sdata));
        end
        if (dump_valid && dump_ready) begin
          if (dump_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dump_extra actual idx=%0d required no word", dump_idx);
          end else begin
            word_t w;
            w = dump_q.pop_front();
            $display("dump word idx=%0d data=%0d", dump_idx, dump_data);
            chk("dump_idx", 32'(dump_idx), 32'(w.idx));
            chk("dump_data", 32'(dump_data), 32'(w.data));
          end
          m_stall = 1'b0;
        end else if (dump_valid) begin
          m_stall = 1'b1;
          m_sidx  = dump_idx;
          m_sdata = dump_data;
        end else begin
          m_stall = 1'b0;
        end
        if (done && !m_prev_done) begin
          if (run_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_extra actual done=1 required no run pending");
          end else begin
            run_t r;
            r = run_q.pop_front();
            $display("run end cycles=%0d timeout=%0d", cycles, timeout);
            chk("cycles", 32'(cycles), 32'(r.cyc));
            chk("timeout", 32'(timeout), 32'(r.to));
            chk("cpu_en_cycles", 32'(m_en_cnt), 32'(r.cyc));
            chk("words_left", 32'(dump_q.size()), 32'd0);
          end
        end
        m_prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_check();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_idx", 32'(dump_idx), 32'd0);
    chk("rst_dump_data", 32'(dump_data), 32'd0);
    chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic apply_reset();
    dump_q.delete();
    run_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mrf[i] = init_val(i);
    $display("reset applied");
    reset_check();
  endtask

  task automatic no_dump_window();
    int n;
    n = 0;
    repeat (30) begin
      tick();
      if (dump_valid) n++;
    end
    chk("no_dump_after_reset", 32'(n), 32'd0);
  endtask

  task automatic pulse_start(input logic [PC_W-1:0] hpc, input logic [CNT_W-1:0] mx);
    halt_pc    = hpc;
    max_cycles = mx;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_run(input logic [PC_W-1:0] hpc, input logic [CNT_W-1:0] mx,
                        input int rmode, input bit inject);
    int kh, len, to, n;
    word_t w;
    run_t  r;
    salt = DATA_W'($urandom);
    // Run length from the rules: halt on RUN cycle halt_pc+1 unless the
    // nonzero budget runs out strictly earlier.
    kh = int'(hpc) + 1;
    if (mx != '0 && int'(mx) < kh) begin
      len = int'(mx);
      to  = 1;
    end else begin
      len = kh;
      to  = 0;
    end
    for (int p = 0; p < len; p++) mrf[p % 16] = wfun(p);
    for (int i = 0; i < NUM_REGS; i++) begin
      w.idx  = i;
      w.data = mrf[i];
      dump_q.push_back(w);
    end
    r.cyc = len;
    r.to  = to;
    run_q.push_back(r);
    ready_mode = rmode;
    $display("run start halt_pc=%0d max_cycles=%0d ready_mode=%0d expect cycles=%0d timeout=%0d",
             hpc, mx, rmode, len, to);
    pulse_start(hpc, mx);
    chk("start_cycles_clear", 32'(cycles), 32'd0);
    chk("start_timeout_clear", 32'(timeout), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    n = 0;
    while (cpu_reset && n < 50) begin
      n++;
      tick();
    end
    chk("cpu_reset_len", 32'(n), 32'(RST_CYCLES));
    if (inject) begin
      tick();
      pulse_start(10'd0, 16'd1);
    end
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk("run_done", 32'(done), 32'd1);
    tick();
    tick();
    ready_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    max_cycles = '0;
    halt_pc    = '0;
    repeat (3) tick();
    apply_reset();

    do_run(10'd8, 16'd0, 0, 1'b0);     // halt run
    do_run(10'd1000, 16'd20, 0, 1'b0); // budget expiry
    do_run(10'd4, 16'd5, 0, 1'b0);     // halt and budget on the same cycle
    do_run(10'd6, 16'd0, 2, 1'b0);     // backpressure on idx 1
    do_run(10'd30, 16'd0, 1, 1'b1);    // ignored start during RUN, restart from DONE
    do_run(10'd0, 16'd1, 0, 1'b0);     // shortest run

    // Reset during RUN
    salt = DATA_W'($urandom);
    pulse_start(10'd1000, 16'd0);
    repeat (10) tick();
    chk("in_run_cpu_en", 32'(cpu_en), 32'd1);
    apply_reset();
    no_dump_window();

    // Reset during DUMP while the consumer stalls
    ready_mode = 3;
    salt = DATA_W'($urandom);
    pulse_start(10'd3, 16'd0);
    n = 0;
    while (!dump_valid && n < 200) begin
      tick();
      n++;
    end
    chk("dump_reached", 32'(dump_valid), 32'd1);
    tick();
    apply_reset();
    ready_mode = 0;
    no_dump_window();

    for (int k = 0; k < 12; k++) begin
      logic [PC_W-1:0]  h;
      logic [CNT_W-1:0] m;
      h = PC_W'($urandom_range(0, 40));
      m = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 40));
      do_run(h, m, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (5) tick();
    chk("final_words_left", 32'(dump_q.size()), 32'd0);
    chk("final_runs_left", 32'(run_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run controller and observer for the monocycle CPU.
- Sequences the CPU through three phases:
  - holds the CPU in reset for a programmable number of cycles;
  - lets it execute until a halt PC is reached or a cycle budget expires;
  - streams a snapshot of the first NUM_REGS register-file entries out over a valid/ready port.
- Replaces fixed-delay, fixed-register inspection with a parametrised, handshaked, in-design equivalent usable in simulation and on hardware.

Parameters:
- DATA_W, 16, width of register-file data and snapshot output.
- PC_W, 10, width of CPU program counter.
- RF_AW, 4, register-file address width.
- NUM_REGS, 4, registers dumped (indices 0..NUM_REGS-1); 1 <= NUM_REGS <= 2**RF_AW.
- RST_CYCLES, 2, cycles cpu_reset is held high after start; >= 1.
- CNT_W, 16, width of cycle counter / budget.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  one-cycle pulse, accepted only in IDLE or DONE.
- max_cycles  in  CNT_W  run budget, sampled on accepted start; 0 = unlimited.
- halt_pc  in  PC_W  halt address, sampled on accepted start.
- cpu_pc  in  PC_W  current CPU program counter.
- cpu_reset  out  1  reset to CPU.
- cpu_en  out  1  CPU clock-enable (register/PC write enable).
- rf_raddr  out  RF_AW  monitor read address into register file.
- rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr.
- dump_valid  out  1  snapshot word valid.
- dump_ready  in  1  consumer ready.
- dump_idx  out  RF_AW  register index of dump_data.
- dump_data  out  DATA_W  register value.
- cycles  out  CNT_W  executed cycles of last/current run.
- busy  out  1  high in RESET, RUN, DUMP.
- done  out  1  high in DONE.
- timeout  out  1  last run ended by budget, not halt_pc.

Behaviour:
- States: IDLE, RESET, RUN, DUMP, DONE.
- On reset (any state, mid-run included):
  - state=IDLE.
  - cpu_reset=1, cpu_en=0.
  - dump_valid=0, dump_idx=0, dump_data=0, rf_raddr=0.
  - cycles=0, busy=0, done=0, timeout=0.
- IDLE: cpu_reset=1, cpu_en=0. start -> RESET; latch max_cycles/halt_pc; clear cycles, timeout; rst counter=0.
- RESET:
  - cpu_reset=1, cpu_en=0.
  - After exactly RST_CYCLES cycles in RESET -> RUN.
  - cpu_reset deasserts on the first RUN cycle.
- RUN:
  - cpu_reset=0, cpu_en=1. cycles increments each RUN cycle, saturating at all-ones.
  - Checks are evaluated every RUN cycle, halt first:
    - halt: cpu_pc==halt_pc_latched -> DUMP, timeout=0.
    - budget: max_cycles!=0 and cycles+1==max_cycles in this cycle -> DUMP, timeout=1.
    - If both are true in the same cycle, halt wins and timeout=0.
  - The cycle that detects halt is counted, and the CPU executes the halt-PC instruction in that cycle.
  - cpu_en=0 from the first DUMP cycle; the CPU is frozen and not reset, so the register state is preserved.
- DUMP:
  - idx runs 0..NUM_REGS-1; rf_raddr=idx.
  - The word is captured into dump_data/dump_idx and dump_valid=1 on the cycle after entering DUMP or after a transfer.
  - Transfer = dump_valid & dump_ready.
  - dump_data/dump_idx hold stable while dump_valid=1 and !dump_ready.
  - After a transfer, the next word becomes valid one cycle later, so dump_valid drops for one cycle between words (2-cycle/word minimum).
  - After the transfer of idx NUM_REGS-1 -> DONE, dump_valid=0.
- DONE:
  - done=1; cpu_en=0, cpu_reset=0 (frozen state inspectable).
  - cycles and timeout hold.
  - start -> RESET (new run).
- start ignored in RESET/RUN/DUMP.
- cycles counter wraps never: saturates.
- busy = state in {RESET, RUN, DUMP}.

Test Plan:
- Halt run: reset 2 cycles, start with halt_pc=8, max_cycles=0; cpu_pc reaches 8 on the 9th RUN cycle, dump_ready=1 -> cpu_reset high exactly 2 cycles after start; cycles=9, timeout=0; dump idx 0,1,2,3 with values matching preloaded RF (e.g. 0,5,7,12); done=1.
- Budget: halt_pc never matched, max_cycles=20 -> exactly 20 cycles with cpu_en=1, cycles=20, timeout=1, full dump follows.
- Simultaneous: cpu_pc==halt_pc on the same cycle as budget expiry (max_cycles=5, halt on 5th) -> timeout=0, cycles=5.
- Backpressure: dump_ready low for 3 cycles on idx 1, then toggling -> dump_data/dump_idx stable while stalled; each idx delivered exactly once, in order.
- Reset mid-operation: assert reset during RUN and again during DUMP -> next cycle all outputs at reset values, cpu_reset=1, no further dump_valid.
- Restart from DONE and ignored start: a start pulse in RUN has no effect; a start in DONE begins a new run with cycles cleared to 0 and timeout cleared.
